// File: rtl/hv_analog_flt_deglitch_if.sv
// Fault-flag bundle between the analog sync stage, the deglitcher and the HV register/report logic.
// Latency: none, this is wiring only.
// Backpressure: none; all signals are level or single-cycle pulse qualified.
// Ports (slave view, as seen by the deglitcher):
//   i_hv_*_err      synced raw analog fault flags
//   i_slow_dgl_cyc  deglitch length for uv/ov/ot
//   i_flt_mask      per-fault exclusion from o_hv_fault / o_flt_int
//   i_flt_clr       per-fault write-1 clear pulse for o_flt_sts
//   o_flt_dgl       deglitched fault level
//   o_flt_sts       sticky fault status
//   o_hv_fault      gate shutdown request
//   o_flt_int       one-cycle interrupt pulse
interface hv_analog_flt_deglitch_if #(
    parameter int DGL_W = 8
);
    logic             i_hv_vcc_uverr;
    logic             i_hv_vcc_overr;
    logic             i_hv_ot_err;
    logic             i_hv_oc_err;
    logic             i_hv_desat_err;
    logic             i_hv_scp_err;
    logic [DGL_W-1:0] i_slow_dgl_cyc;
    logic [5:0]       i_flt_mask;
    logic [5:0]       i_flt_clr;
    logic [5:0]       o_flt_dgl;
    logic [5:0]       o_flt_sts;
    logic             o_hv_fault;
    logic             o_flt_int;

    modport master (
        output i_hv_vcc_uverr, i_hv_vcc_overr, i_hv_ot_err,
        output i_hv_oc_err, i_hv_desat_err, i_hv_scp_err,
        output i_slow_dgl_cyc, i_flt_mask, i_flt_clr,
        input  o_flt_dgl, o_flt_sts, o_hv_fault, o_flt_int
    );

    modport slave (
        input  i_hv_vcc_uverr, i_hv_vcc_overr, i_hv_ot_err,
        input  i_hv_oc_err, i_hv_desat_err, i_hv_scp_err,
        input  i_slow_dgl_cyc, i_flt_mask, i_flt_clr,
        output o_flt_dgl, o_flt_sts, o_hv_fault, o_flt_int
    );
endinterface

// File: rtl/hv_analog_flt_deglitch.sv
// HV analog fault deglitch: per-fault consecutive-sample filter, sticky status, shutdown request and interrupt.
// Latency: dgl/sts after N high samples; o_hv_fault and o_flt_int one cycle after the status change.
// Backpressure: none; inputs are sampled every cycle and outputs are levels or single-cycle pulses.
// Ports: i_clk, i_rst_n (async active-low), io_flt (hv_analog_flt_deglitch_if.slave, see interface file).
// Bit order of every 6-bit vector: [0]vcc_uv [1]vcc_ov [2]ot [3]oc [4]desat [5]scp.
// Optional feature macro HV_FLT_AUTO_CLR_EN: uv/ov/ot status self-clears after RECOV_CYC fault-free cycles.
module hv_analog_flt_deglitch #(
    parameter int DGL_W     = 8,
    parameter int FAST_DGL  = 4,
    parameter int RECOV_CYC = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    hv_analog_flt_deglitch_if.slave        io_flt
);
    localparam logic [DGL_W-1:0] L_FAST_M1 = DGL_W'(FAST_DGL - 1);

    logic [DGL_W-1:0] r_cnt [6];
    logic [5:0]       r_dgl;
    logic [5:0]       r_sts;
    logic [5:0]       r_rise;      // sts bits that went 0->1 on the previous edge
    logic             r_hv_fault;
    logic             r_int;

    logic [5:0]       w_in;
    logic [DGL_W-1:0] w_slow_m1;
    logic [DGL_W-1:0] w_thr_m1 [6];
    logic [DGL_W-1:0] w_cnt_nxt [6];
    logic [5:0]       w_hit;
    logic [5:0]       w_dgl_nxt;
    logic [5:0]       w_sts_nxt;
    logic [5:0]       w_auto_clr;

    assign w_in = {io_flt.i_hv_scp_err, io_flt.i_hv_desat_err, io_flt.i_hv_oc_err,
                   io_flt.i_hv_ot_err, io_flt.i_hv_vcc_overr, io_flt.i_hv_vcc_uverr};

    // A programmed length of 0 behaves like 1 (assert on the first high sample).
    assign w_slow_m1 = (io_flt.i_slow_dgl_cyc == '0) ? '0 : io_flt.i_slow_dgl_cyc - DGL_W'(1);

    always_comb begin
        w_hit     = '0;
        w_dgl_nxt = '0;
        for (int i = 0; i < 6; i++) begin
            w_thr_m1[i]  = (i < 3) ? w_slow_m1 : L_FAST_M1;
            // >= rather than == so a threshold lowered below the running count fires on the next edge.
            w_hit[i]     = (r_cnt[i] >= w_thr_m1[i]);
            w_dgl_nxt[i] = w_in[i] & (r_dgl[i] | w_hit[i]);
            if (!w_in[i])
                w_cnt_nxt[i] = '0;
            else if (w_hit[i])
                w_cnt_nxt[i] = w_thr_m1[i];
            else
                w_cnt_nxt[i] = r_cnt[i] + DGL_W'(1);
        end
    end

`ifdef HV_FLT_AUTO_CLR_EN
    localparam int RCV_W = $clog2(RECOV_CYC + 1);
    logic [RCV_W-1:0] r_rcv [3];

    // Recovery counts cycles with the fault gone but status still latched; any
    // reassertion (dgl high) or manual clear drops the condition and restarts it.
    always_comb begin
        w_auto_clr = '0;
        for (int i = 0; i < 3; i++)
            w_auto_clr[i] = ~r_dgl[i] & r_sts[i] & (r_rcv[i] == RCV_W'(RECOV_CYC - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) r_rcv[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                r_rcv[i] <= (~r_dgl[i] & r_sts[i]) ? r_rcv[i] + RCV_W'(1) : '0;
        end
    end
`else
    assign w_auto_clr = '0;
`endif

    // Set has priority over clear; clear only acts while the fault is currently absent.
    assign w_sts_nxt = w_dgl_nxt | (r_sts & ~((io_flt.i_flt_clr & ~r_dgl) | w_auto_clr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
            r_dgl      <= '0;
            r_sts      <= '0;
            r_rise     <= '0;
            r_hv_fault <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_dgl      <= w_dgl_nxt;
            r_sts      <= w_sts_nxt;
            r_rise     <= w_sts_nxt & ~r_sts;
            r_hv_fault <= |(r_sts & ~io_flt.i_flt_mask);
            // Aligned with o_hv_fault rising; unmasking an old latched bit has no rise, so no pulse.
            r_int      <= |(r_rise & ~io_flt.i_flt_mask);
        end
    end

    assign io_flt.o_flt_dgl  = r_dgl;
    assign io_flt.o_flt_sts  = r_sts;
    assign io_flt.o_hv_fault = r_hv_fault;
    assign io_flt.o_flt_int  = r_int;
endmodule
